// File: rtl/shifter_palette_pkg.sv
// Shared definitions for the shifter palette stage.
//   - resolution encodings, palette depth, channel field masks
//   - expand_nibble(): 3/4-bit palette field -> 4-bit DAC nibble
// Build option: SHIFTER_STE_PALETTE_EN selects 4-bit-per-channel STE entries
// (LSB carried in field bit 3, emitted at the bottom of the nibble).
package shifter_palette_pkg;

  typedef enum logic [1:0] {
    REZ_LOW  = 2'b00,
    REZ_MED  = 2'b01,
    REZ_MONO = 2'b10
  } rez_e;

  localparam int unsigned PAL_ENTRIES = 16;

  localparam logic [15:0] PAL_MASK_ST  = 16'h0777;
  localparam logic [15:0] PAL_MASK_STE = 16'h0FFF;

`ifdef SHIFTER_STE_PALETTE_EN
  localparam bit          STE_EN   = 1'b1;
  localparam logic [15:0] PAL_MASK = PAL_MASK_STE;
`else
  localparam bit          STE_EN   = 1'b0;
  localparam logic [15:0] PAL_MASK = PAL_MASK_ST;
`endif

  // STE keeps the channel LSB in field[3]; plain ST pads the nibble with 0.
  function automatic logic [3:0] expand_nibble(input logic [3:0] field);
    return {field[2:0], field[3] & STE_EN};
  endfunction

endpackage

// File: rtl/shifter_palette_if.sv
// CPU-side palette register port, already synchronised to pixClk.
//   pal_we/pal_re : write / read strobes (one pixClk each)
//   pal_addr      : entry select
//   pal_wdata     : write data (ST/STE word layout)
//   pal_rdata     : readback data, valid while pal_rvalid pulses
// master = bus glue, slave = palette block.
interface shifter_palette_if;
  logic        pal_we;
  logic        pal_re;
  logic [3:0]  pal_addr;
  logic [15:0] pal_wdata;
  logic [15:0] pal_rdata;
  logic        pal_rvalid;

  modport master (
    output pal_we, pal_re, pal_addr, pal_wdata,
    input  pal_rdata, pal_rvalid
  );

  modport slave (
    input  pal_we, pal_re, pal_addr, pal_wdata,
    output pal_rdata, pal_rvalid
  );
endinterface

// File: rtl/shifter_palette_regs.sv
// 16-entry colour palette register file.
//   pixClk, nReset        : clock, async active-low reset (entries <- PAL_RESET)
//   we/addr/wdata         : synchronous write, unimplemented bits dropped
//   re -> rdata/rvalid    : registered CPU readback, one-cycle rvalid pulse
//   lookup_idx/lookup_data: asynchronous pixel lookup (12-bit field view)
//   entry0_lsb            : bit 0 of entry 0, used by the mono path
// Build option: SHIFTER_STE_PALETTE_EN (via the package mask).
module shifter_palette_regs
  import shifter_palette_pkg::*;
#(
  parameter logic [15:0] PAL_RESET = 16'h0000
) (
  input  logic        pixClk,
  input  logic        nReset,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        rvalid,
  input  logic [3:0]  lookup_idx,
  output logic [11:0] lookup_data,
  output logic        entry0_lsb
);

  localparam logic [11:0] FIELD_MASK  = PAL_MASK[11:0];
  localparam logic [11:0] RESET_FIELD = PAL_RESET[11:0] & FIELD_MASK;

  logic [11:0] pal_q [PAL_ENTRIES];
  logic [15:0] rdata_q;
  logic        rvalid_q;

  // Upper nibble of the bus word has no storage behind it.
  logic unused_wdata;
  assign unused_wdata = ^wdata[15:12];

  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      for (int unsigned i = 0; i < PAL_ENTRIES; i++) begin
        pal_q[i] <= RESET_FIELD;
      end
    end else if (we) begin
      pal_q[addr] <= wdata[11:0] & FIELD_MASK;
    end
  end

  // Read samples the pre-write contents, so a colliding read sees the old value.
  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      rdata_q  <= 16'h0000;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= re;
      if (re) begin
        rdata_q <= {4'h0, pal_q[addr]};
      end
    end
  end

  assign rdata       = rdata_q;
  assign rvalid      = rvalid_q;
  assign lookup_data = pal_q[lookup_idx];
  assign entry0_lsb  = pal_q[0][0];

endmodule

// File: rtl/shifter_palette.sv
// Shifter output stage: colour index -> palette lookup -> RGB / mono drive.
//   pixClk, nReset            : pixel clock, async active-low reset
//   rez                       : 00 low, 01 med, 1x mono
//   DE, nBlank, color_index   : pixel stream from the shifter
//   pal_bus (slave)           : CPU palette write/readback port
//   R, G, B, mono_out         : colour drive
//   DE_out, nBlank_out        : DE/nBlank delayed to match R/G/B
// Pixel latency is 1 + OUT_REG pixClk.
// Build option: SHIFTER_STE_PALETTE_EN (4-bit STE palette channels).
module shifter_palette
  import shifter_palette_pkg::*;
#(
  parameter int unsigned OUT_REG   = 1,
  parameter logic [15:0] PAL_RESET = 16'h0000
) (
  input  logic              pixClk,
  input  logic              nReset,
  input  logic [1:0]        rez,
  input  logic              DE,
  input  logic              nBlank,
  input  logic [3:0]        color_index,
  shifter_palette_if.slave  pal_bus,
  output logic [3:0]        R,
  output logic [3:0]        G,
  output logic [3:0]        B,
  output logic              mono_out,
  output logic              DE_out,
  output logic              nBlank_out
);

  // Stage 1 registers
  logic [3:0] ci_q;
  logic       de_q;
  logic       nblank_q;
  rez_e       rez_q;

  always_ff @(posedge pixClk or negedge nReset) begin
    if (!nReset) begin
      ci_q     <= 4'h0;
      de_q     <= 1'b0;
      nblank_q <= 1'b0;
      rez_q    <= REZ_LOW;
    end else begin
      ci_q     <= color_index;
      de_q     <= DE;
      nblank_q <= nBlank;
      rez_q    <= rez_e'(rez);
    end
  end

  logic [3:0]  idx;
  logic [11:0] entry;
  logic        entry0_lsb;
  logic        white;

  // Border (DE low) shows entry 0; medium res only has four colours.
  always_comb begin
    idx = de_q ? ci_q : 4'h0;
    if (rez_q == REZ_MED) begin
      idx = {2'b00, idx[1:0]};
    end
  end

  shifter_palette_regs #(
    .PAL_RESET (PAL_RESET)
  ) u_regs (
    .pixClk      (pixClk),
    .nReset      (nReset),
    .we          (pal_bus.pal_we),
    .re          (pal_bus.pal_re),
    .addr        (pal_bus.pal_addr),
    .wdata       (pal_bus.pal_wdata),
    .rdata       (pal_bus.pal_rdata),
    .rvalid      (pal_bus.pal_rvalid),
    .lookup_idx  (idx),
    .lookup_data (entry),
    .entry0_lsb  (entry0_lsb)
  );

  // Entry 0 bit 0 inverts the mono screen polarity.
  assign white = idx[0] ^ entry0_lsb;

  logic [3:0] r_s1, g_s1, b_s1;
  logic       mono_s1;

  always_comb begin
    r_s1    = 4'h0;
    g_s1    = 4'h0;
    b_s1    = 4'h0;
    mono_s1 = 1'b0;
    if (nblank_q) begin
      if (rez_q[1]) begin
        r_s1    = {4{white}};
        g_s1    = {4{white}};
        b_s1    = {4{white}};
        mono_s1 = white;
      end else begin
        r_s1 = expand_nibble(entry[11:8]);
        g_s1 = expand_nibble(entry[7:4]);
        b_s1 = expand_nibble(entry[3:0]);
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    always_ff @(posedge pixClk or negedge nReset) begin
      if (!nReset) begin
        R          <= 4'h0;
        G          <= 4'h0;
        B          <= 4'h0;
        mono_out   <= 1'b0;
        DE_out     <= 1'b0;
        nBlank_out <= 1'b0;
      end else begin
        R          <= r_s1;
        G          <= g_s1;
        B          <= b_s1;
        mono_out   <= mono_s1;
        DE_out     <= de_q;
        nBlank_out <= nblank_q;
      end
    end
  end else begin : g_out_comb
    assign R          = r_s1;
    assign G          = g_s1;
    assign B          = b_s1;
    assign mono_out   = mono_s1;
    assign DE_out     = de_q;
    assign nBlank_out = nblank_q;
  end

endmodule

// File: doc/shifter_palette.md
Name: shifter_palette

Overview:
Downstream stage of the async video shifter. Consumes the per-pixel colour_index, the DE window and blanking, and turns them into RGB/mono drive through the 16-entry ST colour palette register file. Also owns the CPU-side palette register write/readback port, already synchronised to pixClk by the bus glue. Sits between the shifter and the video DAC/scan-doubler.

Parameters:
OUT_REG, 1, 1 = extra output register stage (pixel latency 2); 0 = latency 1.
PAL_RESET, 16'h0000, reset value loaded into every palette entry.

Ports:
pixClk  in  1  pixel clock; all logic rising-edge.
nReset  in  1  asynchronous, active-low reset.
rez  in  2  resolution: 00 low, 01 med, 10 mono, 11 treated as mono.
DE  in  1  display enable, aligned with color_index.
nBlank  in  1  active-low blank, aligned with color_index.
color_index  in  4  pixel colour index from shifter.
pal_we  in  1  palette write strobe, one pixClk per write.
pal_re  in  1  palette read strobe.
pal_addr  in  4  palette entry select.
pal_wdata  in  16  write data, ST/STE word layout (R [10:8], G [6:4], B [2:0]).
pal_rdata  out  16  readback data.
pal_rvalid  out  1  readback valid pulse.
R, G, B  out  4 each  colour drive.
mono_out  out  1  monochrome pixel (1 = white).
DE_out, nBlank_out  out  1 each  DE/nBlank delayed to match R/G/B.

Behaviour:
- Reset (async, nReset low): all 16 entries = PAL_RESET; R/G/B = 0; mono_out = 0; DE_out = 0; nBlank_out = 0; pal_rdata = 0; pal_rvalid = 0; pipeline registers cleared.
- Stage 1, every pixClk: register color_index, DE, nBlank, rez.
- Stage 1 index: index = DE ? color_index : 0 (border shows entry 0).
  - rez=01: index masked to [1:0].
  - rez=1x: mono path.
- Stage 2 (present if OUT_REG=1): R/G/B/mono_out/DE_out/nBlank_out registered again. Otherwise driven from stage-1 lookup.
- Latency: color_index to R/G/B = 1+OUT_REG pixClk.
- Colour path: channel nibble = {entry field[2:0], 0}.
- Mono path: white = registered idx[0] XOR pal[0][0] (DE low gives idx 0).
  - R/G/B = white ? 4'hF : 4'h0.
  - mono_out = white.
  - With PAL_RESET=0 the background is black.
- Blank: registered nBlank=0 forces R/G/B=0 and mono_out=0. DE_out/nBlank_out still propagate.
- Palette write: on pixClk with pal_we=1, entry[pal_addr] <= masked pal_wdata. The new value is used by stage-1 lookups from the next cycle. A same-cycle lookup of that entry returns the old value.
- Readback: pal_re=1 gives, next cycle, pal_rdata = entry[pal_addr] (unimplemented bits = 0) and pal_rvalid = 1 for one cycle.
- pal_we and pal_re together on the same address: read returns the old value; the write still lands.
- Back-to-back writes: one per cycle, last wins.
- rez change: takes effect on the next stage-1 register.
- No state besides the palette and pipeline.
- Reset mid-line clears the palette to PAL_RESET immediately. Outputs are 0 until pixels re-flow.

Optional Feature:
SHIFTER_STE_PALETTE_EN.
- Defined:
  - Entries store 4 bits per channel: R [11:8], G [7:4], B [3:0].
  - Output nibble = {field[2:0], field[3]} (STE LSB-at-top format).
  - Readback returns all 12 bits.
  - Mono uses bit 0 of entry 0.
- Undefined:
  - Bits [11],[7],[3] are not stored and read back 0.
  - Output nibble = {field[2:0], 0}.

Decomposition:
- shifter_pkg:
  - rez encodings (REZ_LOW/MED/MONO).
  - PAL_ENTRIES=16.
  - Channel field masks ST (16'h0777) and STE (16'h0FFF).
  - Nibble-expansion function.
- Sub-module shifter_palette_regs: 16-entry register file with synchronous write, asynchronous lookup read port and registered CPU read port. Top level holds the pipeline and mono/blank muxing.

Test Plan:
- Reset with PAL_RESET=0 → R/G/B=0, pal_rvalid=0; read any entry → pal_rdata=0.
- rez=00, write entry 5=16'h0724, then DE=1, index 5 → after 2 pixClk R=E, G=4, B=8; same-cycle write/lookup of entry 5 → old value for that pixel.
- rez=01, index 4'hF with entry 3=16'h0070, entry 15=16'h0700 → entry 3 colour (G=E), not entry 15; DE=0 → entry 0 colour.
- rez=10, entry 0=16'h0001, idx[0]=0 → mono_out=1 and RGB=F; idx[0]=1 → mono_out=0, RGB=0; nBlank=0 → RGB=0 while nBlank_out=0 tracks.
- pal_we+pal_re same cycle on address 9, old 16'h0111, new 16'h0222 → pal_rdata=16'h0111, following read 16'h0222; write 16'hFFFF → read 16'h0777 (16'h0FFF with SHIFTER_STE_PALETTE_EN).
- SHIFTER_STE_PALETTE_EN, entry 1=16'h0F81 → R=F, G=1, B=2.
